// File: rtl/distance_obstacle_guard_if.sv
// Sensor-side bus of the obstacle guard: distance strobe in, filtered distance and zone flags out.
interface distance_obstacle_guard_if;
   logic [7:0] distance;
   logic       distance_valid;
   logic [7:0] filtered_distance;
   logic [1:0] zone;
   logic       stop;
   logic       slow;
   logic       stale;

   modport master (
      output distance, distance_valid,
      input  filtered_distance, zone, stop, slow, stale
   );

   modport slave (
      input  distance, distance_valid,
      output filtered_distance, zone, stop, slow, stale
   );
endinterface

// File: rtl/distance_obstacle_guard.sv
// Moving-average filter plus CLEAR/SLOW/STOP zone classifier with hysteresis, confirmation
// and a stale-reading fail-safe that forces STOP.
module distance_obstacle_guard #(
   parameter int unsigned WIN_LOG2    = 2,
   parameter int unsigned STOP_CM     = 20,
   parameter int unsigned SLOW_CM     = 40,
   parameter int unsigned HYST_CM     = 5,
   parameter int unsigned CONFIRM     = 2,
   parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
   input logic                       clk,
   input logic                       rst,
   distance_obstacle_guard_if.slave  bus
);
   localparam int unsigned N  = 1 << WIN_LOG2;
   localparam int unsigned SW = 8 + WIN_LOG2;
   localparam int unsigned FW = WIN_LOG2 + 1;
   localparam int unsigned CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ZoneClear = 2'd0;
   localparam logic [1:0] ZoneSlow  = 2'd1;
   localparam logic [1:0] ZoneStop  = 2'd2;

   localparam logic [7:0] StopThr  = 8'(STOP_CM);
   localparam logic [7:0] SlowThr  = 8'(SLOW_CM);
   localparam logic [7:0] StopExit = 8'(STOP_CM + HYST_CM);
   localparam logic [7:0] SlowExit = 8'(SLOW_CM + HYST_CM);

   logic [7:0]    win_q [N];
   logic [SW-1:0] sum_q, sum_d;
   logic [7:0]    filt_q;
   logic [FW-1:0] fill_q;
   logic          eval_q;
   logic [1:0]    zone_q, zone_d;
   logic [CW-1:0] conf_q, conf_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          stale_q, stale_d;
   logic          timeout_hit;
   logic          qualify;

   // Sum stays exact: it always equals the total of the N window entries.
   assign sum_d = sum_q + SW'(bus.distance) - SW'(win_q[N-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) win_q[i] <= '0;
         sum_q   <= '0;
         filt_q  <= '0;
         fill_q  <= '0;
         eval_q  <= 1'b0;
         zone_q  <= ZoneStop;
         conf_q  <= '0;
         tmo_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         if (bus.distance_valid) begin
            win_q[0] <= bus.distance;
            for (int i = 1; i < N; i++) win_q[i] <= win_q[i-1];
            sum_q  <= sum_d;
            filt_q <= 8'(sum_d >> WIN_LOG2);
            if (fill_q != FW'(N)) fill_q <= fill_q + FW'(1);
         end
         // The Nth valid after reset is the first one evaluated.
         eval_q  <= bus.distance_valid && (fill_q >= FW'(N - 1));
         zone_q  <= zone_d;
         conf_q  <= conf_d;
         tmo_q   <= tmo_d;
         stale_q <= stale_d;
      end
   end

   always_comb begin
      tmo_d       = tmo_q;
      stale_d     = stale_q;
      timeout_hit = 1'b0;
      if (bus.distance_valid) begin
         tmo_d   = '0;
         stale_d = 1'b0;
      end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
         tmo_d = tmo_q + TW'(1);
         if (tmo_d == TW'(TIMEOUT_CYC)) begin
            stale_d     = 1'b1;
            timeout_hit = 1'b1;
         end
      end
   end

   always_comb begin
      zone_d  = zone_q;
      conf_d  = conf_q;
      qualify = 1'b0;
      if (timeout_hit) begin
         zone_d = ZoneStop;
         conf_d = '0;
      end else if (eval_q) begin
         if (filt_q < StopThr) begin
            zone_d = ZoneStop;
            conf_d = '0;
         end else if (zone_q == ZoneClear) begin
            if (filt_q < SlowThr) zone_d = ZoneSlow;
            conf_d = '0;
         end else begin
            qualify = (zone_q == ZoneStop) ? (filt_q >= StopExit) : (filt_q >= SlowExit);
            if (!qualify) begin
               conf_d = '0;
            end else if (conf_q == CW'(CONFIRM - 1)) begin
               zone_d = (zone_q == ZoneStop) ? ZoneSlow : ZoneClear;
               conf_d = '0;
            end else begin
               conf_d = conf_q + CW'(1);
            end
         end
      end
   end

   assign bus.filtered_distance = filt_q;
   assign bus.zone              = zone_q;
   assign bus.stop              = (zone_q == ZoneStop);
   assign bus.slow              = (zone_q == ZoneSlow);
   assign bus.stale             = stale_q;
endmodule
